// File: rtl/spad_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// spad_fifo_ctrl
//
// Purpose:
//   Pointer and occupancy controller that runs a single-port-write /
//   single-port-read PE scratchpad as a circular FIFO (ifmap or psum staging).
//   The producer side uses a valid/ready handshake. The consumer side uses a
//   request/grant handshake with a registered data-valid strobe, which matches
//   the scratchpad's 1-cycle read latency. All state updates on the falling
//   edge of clk.
//
// Optional feature:
//   SPAD_FIFO_WATERMARK_EN  - when defined, adds the registered almost_full
//                             output, which is set when occupancy >= WM_LEVEL.
//
// Parameters:
//   DEPTH     number of scratchpad entries (>= 2, any integer)
//   AW        scratchpad address width
//   CW        occupancy counter width
//   WM_LEVEL  almost-full threshold (used only with the watermark feature)
//
// Ports:
//   clk            clock (falling-edge active)
//   reset          asynchronous, active-high reset
//   flush          synchronous clear of pointers, count and pending read
//   wr_valid       producer has a word to write
//   wr_ready       controller can accept a write (= !full)
//   rd_req         consumer requests one word
//   rd_gnt         read granted this cycle
//   rd_data_valid  scratchpad read data valid, 1 cycle after rd_gnt
//   spad_we        scratchpad write enable
//   spad_waddr     scratchpad write address (write pointer)
//   spad_re        scratchpad read enable (= rd_gnt)
//   spad_raddr     scratchpad read address (read pointer)
//   count          current occupancy, 0..DEPTH
//   full           count == DEPTH
//   empty          count == 0
//   almost_full    watermark flag (only with SPAD_FIFO_WATERMARK_EN)
// -----------------------------------------------------------------------------
module spad_fifo_ctrl #(
    parameter int DEPTH    = 12,
    parameter int AW       = $clog2(DEPTH),
    parameter int CW       = $clog2(DEPTH + 1),
    parameter int WM_LEVEL = DEPTH - 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic          rd_req,
    output logic          rd_gnt,
    output logic          rd_data_valid,
    output logic          spad_we,
    output logic [AW-1:0] spad_waddr,
    output logic          spad_re,
    output logic [AW-1:0] spad_raddr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
`ifdef SPAD_FIFO_WATERMARK_EN
    ,
    output logic          almost_full
`endif
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // -------------------------------------------------------------------------
    if (DEPTH < 2 || WM_LEVEL < 0 || WM_LEVEL > DEPTH) begin : g_bad_param
        $error("spad_fifo_ctrl: DEPTH must be >= 2 and WM_LEVEL in 0..DEPTH");
    end

    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          rd_dv;

    logic [AW-1:0] wptr_nxt;
    logic [AW-1:0] rptr_nxt;
    logic [CW-1:0] cnt_nxt;

    // -------------------------------------------------------------------------
    // Status and handshake decode
    //
    // wr_ready depends only on the count register and rd_gnt only on the
    // count register, rd_req and flush, so there is no path from rd_req to
    // wr_ready or from wr_valid to rd_gnt. In particular a full FIFO refuses
    // writes even when a read is granted in the same cycle, and an empty FIFO
    // never grants on the strength of a same-cycle write.
    // -------------------------------------------------------------------------
    always_comb begin
        full     = (cnt == CNT_DEPTH);
        empty    = (cnt == '0);
        wr_ready = !full;
        spad_we  = wr_valid & !full & !flush;
        rd_gnt   = rd_req & !empty & !flush;
        spad_re  = rd_gnt;
    end

    assign spad_waddr    = wptr;
    assign spad_raddr    = rptr;
    assign count         = cnt;
    assign rd_data_valid = rd_dv;

    // -------------------------------------------------------------------------
    // Next-state computation
    //
    // Pointers wrap explicitly at DEPTH-1 because DEPTH need not be a power
    // of two. Flush overrides any traffic and returns everything to zero.
    // -------------------------------------------------------------------------
    always_comb begin
        wptr_nxt = wptr;
        rptr_nxt = rptr;
        cnt_nxt  = cnt;

        if (flush) begin
            wptr_nxt = '0;
            rptr_nxt = '0;
            cnt_nxt  = '0;
        end else begin
            if (spad_we) begin
                wptr_nxt = (wptr == PTR_LAST) ? '0 : wptr + AW'(1);
            end
            if (rd_gnt) begin
                rptr_nxt = (rptr == PTR_LAST) ? '0 : rptr + AW'(1);
            end
            case ({spad_we, rd_gnt})
                2'b10:   cnt_nxt = cnt + CW'(1);
                2'b01:   cnt_nxt = cnt - CW'(1);
                default: cnt_nxt = cnt;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    //
    // rd_dv is a plain registered copy of rd_gnt. Because a flush forces
    // rd_gnt low, a grant issued the cycle before a flush still produces its
    // valid pulse during the flush cycle, and the flush edge then clears it.
    // -------------------------------------------------------------------------
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            rd_dv <= 1'b0;
        end else begin
            wptr  <= wptr_nxt;
            rptr  <= rptr_nxt;
            cnt   <= cnt_nxt;
            rd_dv <= rd_gnt;
        end
    end

`ifdef SPAD_FIFO_WATERMARK_EN
    // -------------------------------------------------------------------------
    // Almost-full watermark, registered from the next count so it lines up
    // with the count register rather than lagging it by a cycle.
    // -------------------------------------------------------------------------
    localparam logic [CW-1:0] CNT_WM = CW'(WM_LEVEL);

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            almost_full <= 1'b0;
        end else if (flush) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (cnt_nxt >= CNT_WM);
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Simulation checks: occupancy stays within 0..DEPTH and agrees with the
    // pointer distance (full is the one case where the pointers coincide with
    // a non-zero count).
    // -------------------------------------------------------------------------
    a_count_max: assert property (@(negedge clk) disable iff (reset)
        cnt <= CNT_DEPTH);

    a_no_underflow: assert property (@(negedge clk) disable iff (reset)
        !(empty && spad_re));

    a_no_overflow: assert property (@(negedge clk) disable iff (reset)
        !(full && spad_we));

    a_ptr_invariant: assert property (@(negedge clk) disable iff (reset)
        (full && (wptr == rptr)) ||
        (!full && (int'(cnt) == ((int'(wptr) - int'(rptr) + DEPTH) % DEPTH))));

endmodule

// File: tb/tb_spad_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spad_fifo_ctrl
//
// Directed bench for spad_fifo_ctrl at DEPTH=4, WM_LEVEL=2. Inputs change
// 1 time unit after the falling (active) edge; combinational outputs are
// checked before the next falling edge and registered state 1 time unit
// after it.
// -----------------------------------------------------------------------------
module tb_spad_fifo_ctrl;

    localparam int DEPTH    = 4;
    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = $clog2(DEPTH + 1);
    localparam int WM_LEVEL = 2;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          wr_valid;
    logic          wr_ready;
    logic          rd_req;
    logic          rd_gnt;
    logic          rd_data_valid;
    logic          spad_we;
    logic [AW-1:0] spad_waddr;
    logic          spad_re;
    logic [AW-1:0] spad_raddr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
`ifdef SPAD_FIFO_WATERMARK_EN
    logic          almost_full;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    spad_fifo_ctrl #(
        .DEPTH    (DEPTH),
        .WM_LEVEL (WM_LEVEL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .rd_req        (rd_req),
        .rd_gnt        (rd_gnt),
        .rd_data_valid (rd_data_valid),
        .spad_we       (spad_we),
        .spad_waddr    (spad_waddr),
        .spad_re       (spad_re),
        .spad_raddr    (spad_raddr),
        .count         (count),
        .full          (full),
        .empty         (empty)
`ifdef SPAD_FIFO_WATERMARK_EN
        ,
        .almost_full   (almost_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one active (falling) edge and settle.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic f);
        wr_valid = w;
        rd_req   = r;
        flush    = f;
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // ---- reset state ----
        check("rst_empty",    32'(empty), 1);
        check("rst_full",     32'(full), 0);
        check("rst_count",    32'(count), 0);
        check("rst_wr_ready", 32'(wr_ready), 1);
        check("rst_rd_dv",    32'(rd_data_valid), 0);
`ifdef SPAD_FIFO_WATERMARK_EN
        check("rst_af",       32'(almost_full), 0);
`endif

        // ---- read request while empty: no grant ----
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0);
            check("empty_gnt", 32'(rd_gnt), 0);
            check("empty_re",  32'(spad_re), 0);
            tick();
            check("empty_dv",  32'(rd_data_valid), 0);
        end

        // ---- fill with 4 writes ----
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0);
            check("fill_we",    32'(spad_we), 1);
            check("fill_waddr", 32'(spad_waddr), 32'(i));
            tick();
            check("fill_count", 32'(count), 32'(i + 1));
`ifdef SPAD_FIFO_WATERMARK_EN
            check("fill_af",    32'(almost_full), (i + 1 >= WM_LEVEL) ? 1 : 0);
`endif
        end
        check("full_flag",     32'(full), 1);
        check("full_wr_ready", 32'(wr_ready), 0);

        // 5th write attempt while full
        drive(1, 0, 0);
        check("full_we", 32'(spad_we), 0);
        tick();
        check("full_count", 32'(count), 4);
        check("full_waddr", 32'(spad_waddr), 0);

        // ---- drain with 4 grants ----
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0);
            check("drain_gnt",   32'(rd_gnt), 1);
            check("drain_re",    32'(spad_re), 1);
            check("drain_raddr", 32'(spad_raddr), 32'(i));
            tick();
            check("drain_dv",    32'(rd_data_valid), 1);
            check("drain_count", 32'(count), 32'(3 - i));
        end
        drive(0, 0, 0);
        tick();
        check("drain_dv_off", 32'(rd_data_valid), 0);
        check("drain_empty",  32'(empty), 1);

        // ---- empty: same-cycle write does not bypass into a grant ----
        drive(1, 1, 0);
        check("nobypass_gnt", 32'(rd_gnt), 0);
        check("nobypass_we",  32'(spad_we), 1);
        tick();
        check("nobypass_dv",    32'(rd_data_valid), 0);
        check("nobypass_count", 32'(count), 1);

        // ---- flush blocks traffic and clears state (count=1, wptr=1) ----
        drive(1, 1, 1);
        check("flush_gnt", 32'(rd_gnt), 0);
        check("flush_we",  32'(spad_we), 0);
        tick();
        check("flush_count", 32'(count), 0);
        check("flush_waddr", 32'(spad_waddr), 0);
        check("flush_raddr", 32'(spad_raddr), 0);

        // ---- pointer wrap: 3 writes, 3 reads, 3 writes ----
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0);
            check("wrap_raddr", 32'(spad_raddr), 32'(i));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0);
            check("wrap_waddr", 32'(spad_waddr), (i == 0) ? 3 : 32'(i - 1));
            tick();
        end
        check("wrap_count", 32'(count), 3);

        // one read: wptr=2, rptr=0, count=2
        drive(0, 1, 0);
        check("pre_sim_raddr", 32'(spad_raddr), 3);
        tick();
        check("pre_sim_count", 32'(count), 2);

        // ---- simultaneous write + grant for 5 cycles ----
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0);
            check("sim_we",  32'(spad_we), 1);
            check("sim_gnt", 32'(rd_gnt), 1);
            tick();
            check("sim_count", 32'(count), 2);
        end
        check("sim_waddr", 32'(spad_waddr), 3);
        check("sim_raddr", 32'(spad_raddr), 1);

        // fill to 4: wptr=1, rptr=1
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0);
            tick();
        end
        check("refill_full", 32'(full), 1);

        // ---- full: write and read together -> only the read happens ----
        drive(1, 1, 0);
        check("fullrw_we",  32'(spad_we), 0);
        check("fullrw_gnt", 32'(rd_gnt), 1);
        tick();
        check("fullrw_count", 32'(count), 3);
        check("fullrw_waddr", 32'(spad_waddr), 1);
        check("fullrw_raddr", 32'(spad_raddr), 2);
        check("fullrw_dv",    32'(rd_data_valid), 1);

        // idle, then a grant (with write) at count=3, then flush
        drive(0, 0, 0);
        tick();
        check("idle_dv", 32'(rd_data_valid), 0);
        drive(1, 1, 0);
        tick();
        check("preflush_count", 32'(count), 3);
`ifdef SPAD_FIFO_WATERMARK_EN
        check("preflush_af",    32'(almost_full), 1);
`endif
        drive(1, 1, 1);
        check("flush2_dv",  32'(rd_data_valid), 1);
        check("flush2_gnt", 32'(rd_gnt), 0);
        check("flush2_we",  32'(spad_we), 0);
        tick();
        check("flush2_dv_off", 32'(rd_data_valid), 0);
        check("flush2_count",  32'(count), 0);
        check("flush2_waddr",  32'(spad_waddr), 0);
        check("flush2_raddr",  32'(spad_raddr), 0);
        check("flush2_empty",  32'(empty), 1);
`ifdef SPAD_FIFO_WATERMARK_EN
        check("flush2_af",     32'(almost_full), 0);
`endif

        // ---- async reset mid-write ----
        drive(1, 0, 0);
        tick();
        tick();
        drive(1, 1, 0);
        tick();
        check("prerst_count", 32'(count), 2);
        check("prerst_dv",    32'(rd_data_valid), 1);
        check("prerst_waddr", 32'(spad_waddr), 3);
        drive(1, 0, 0);
        #1;
        reset = 1'b1;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_waddr", 32'(spad_waddr), 0);
        check("arst_raddr", 32'(spad_raddr), 0);
        check("arst_dv",    32'(rd_data_valid), 0);
        check("arst_empty", 32'(empty), 1);
        check("arst_we",    32'(spad_we), 1);
`ifdef SPAD_FIFO_WATERMARK_EN
        check("arst_af",    32'(almost_full), 0);
`endif
        drive(0, 0, 0);
        tick();
        reset = 1'b0;
        #1;
        drive(1, 0, 0);
        tick();
        check("post_rst_count", 32'(count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
